votacao_jogadores: RTL

VOTACAO_JOGADORES -- requirements
Module: votacao_jogadores

---
 rtl/votacao_jogadores.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/votacao_jogadores.sv
// Voting-round controller: collects one vote (or abstention) per alive
// player in index order, then tallies the counters to find who is
// eliminated, flagging ties and reporting the highest vote count.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  OCIOSO  | idle, waiting for iniciar
//  PROXIMO | scanning for the next alive voter
//  ESPERA  | waiting for a valid vote or passa from the current voter
//  SOLTA   | waiting for all buttons released before moving on
//  APURA   | tallying counters, one per cycle
//  FIM     | result valid, pronto pulse
module votacao_jogadores #(
    parameter int N_JOG  = 5,
    parameter int W_JOG  = 3,
    parameter int W_VOTO = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [N_JOG-1:0]  vivos,
    input  logic [N_JOG-1:0]  botoes,
    input  logic              passa,
    output logic              ocupado,
    output logic [W_JOG-1:0]  jogador_votante,
    output logic              pronto,
    output logic [W_JOG-1:0]  eliminado,
    output logic              empate,
    output logic [W_VOTO-1:0] votos_max,
    output logic [2:0]        db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PROXIMO = 3'd1,
        ESPERA  = 3'd2,
        SOLTA   = 3'd3,
        APURA   = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam logic [W_JOG-1:0]  IDX_NINGUEM = W_JOG'(N_JOG);
    localparam logic [W_JOG-1:0]  IDX_ULTIMO  = W_JOG'(N_JOG - 1);
    localparam logic [W_VOTO-1:0] VOTO_SAT    = '1;

    estado_t estado, prox_estado;

    logic [N_JOG-1:0]  vivos_lat;
    logic [W_JOG-1:0]  votante;
    logic [W_JOG-1:0]  idx_apura;
    logic [W_VOTO-1:0] votos [N_JOG];

    logic [W_VOTO-1:0] max_ac;
    logic [W_JOG-1:0]  idx_max_ac;
    logic              empate_ac;

    logic [W_VOTO-1:0] max_n;
    logic [W_JOG-1:0]  idx_max_n;
    logic              empate_n;

    logic              votante_vivo;
    logic [W_JOG-1:0]  alvo_idx;
    logic [W_VOTO-1:0] contagem;
    logic              um_bit;
    logic              alvo_vivo;
    logic              auto_voto;
    logic              voto_valido;
    logic              fim_varredura;
    logic              inicio;
    logic              registra_voto;

    assign inicio        = (estado == OCIOSO) && iniciar;
    assign um_bit        = (botoes != '0) && ((botoes & (botoes - N_JOG'(1))) == '0);
    assign alvo_vivo     = |(botoes & vivos_lat);
    assign auto_voto     = (botoes == (N_JOG'(1) << votante));
    assign voto_valido   = um_bit && alvo_vivo && !auto_voto;
    assign registra_voto = (estado == ESPERA) && voto_valido && !passa;
    // An empty mask has no voter to wait for, so the scan goes straight
    // to tallying instead of stepping through every dead index.
    assign fim_varredura = (votante == IDX_NINGUEM) || (vivos_lat == '0);

    // Index-based lookups: voter liveness, vote target, counter under tally.
    always_comb begin
        votante_vivo = 1'b0;
        alvo_idx     = '0;
        contagem     = '0;
        for (int i = 0; i < N_JOG; i++) begin
            if (votante == W_JOG'(i)) votante_vivo = vivos_lat[i];
            if (botoes[i])            alvo_idx     = W_JOG'(i);
            if (idx_apura == W_JOG'(i)) contagem   = votos[i];
        end
    end

    // Running maximum / tie update for the counter currently being tallied.
    always_comb begin
        max_n     = max_ac;
        idx_max_n = idx_max_ac;
        empate_n  = empate_ac;
        if (contagem > max_ac) begin
            max_n     = contagem;
            idx_max_n = idx_apura;
            empate_n  = 1'b0;
        end else if ((contagem == max_ac) && (max_ac != '0)) begin
            empate_n  = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox_estado;
    end

    // Next-state logic.
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (iniciar) prox_estado = PROXIMO;
            PROXIMO: begin
                if (fim_varredura)     prox_estado = APURA;
                else if (votante_vivo) prox_estado = ESPERA;
                else                   prox_estado = PROXIMO;
            end
            ESPERA:  if (passa || voto_valido) prox_estado = SOLTA;
            SOLTA:   if (botoes == '0) prox_estado = PROXIMO;
            APURA:   if (idx_apura == IDX_ULTIMO) prox_estado = FIM;
            FIM:     prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // Outputs decoded from the state.
    always_comb begin
        ocupado         = (estado != OCIOSO);
        pronto          = (estado == FIM);
        jogador_votante = ((estado == ESPERA) || (estado == SOLTA)) ? votante : '0;
        db_estado       = estado;
    end

    // Round setup: latch the alive mask and advance the voter index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vivos_lat <= '0;
            votante   <= '0;
        end else if (inicio) begin
            vivos_lat <= vivos;
            votante   <= '0;
        end else if ((estado == PROXIMO) && !fim_varredura && !votante_vivo) begin
            votante   <= votante + W_JOG'(1);
        end else if ((estado == SOLTA) && (botoes == '0)) begin
            votante   <= votante + W_JOG'(1);
        end
    end

    // Per-player vote counters, saturating so a full counter never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_JOG; i++) votos[i] <= '0;
        end else begin
            for (int i = 0; i < N_JOG; i++) begin
                if (inicio) begin
                    votos[i] <= '0;
                end else if (registra_voto && (alvo_idx == W_JOG'(i)) &&
                             (votos[i] != VOTO_SAT)) begin
                    votos[i] <= votos[i] + W_VOTO'(1);
                end
            end
        end
    end

    // Tally accumulators: one counter is folded in per APURA cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_apura  <= '0;
            max_ac     <= '0;
            idx_max_ac <= '0;
            empate_ac  <= 1'b0;
        end else if (inicio) begin
            idx_apura  <= '0;
            max_ac     <= '0;
            idx_max_ac <= '0;
            empate_ac  <= 1'b0;
        end else if (estado == APURA) begin
            idx_apura  <= idx_apura + W_JOG'(1);
            max_ac     <= max_n;
            idx_max_ac <= idx_max_n;
            empate_ac  <= empate_n;
        end
    end

    // Result registers: loaded on the last tally cycle, held until the next.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            eliminado <= IDX_NINGUEM;
            empate    <= 1'b0;
            votos_max <= '0;
        end else if ((estado == APURA) && (idx_apura == IDX_ULTIMO)) begin
            votos_max <= max_n;
            if (max_n == '0) begin
                eliminado <= IDX_NINGUEM;
                empate    <= 1'b0;
            end else if (empate_n) begin
                eliminado <= IDX_NINGUEM;
                empate    <= 1'b1;
            end else begin
                eliminado <= idx_max_n;
                empate    <= 1'b0;
            end
        end
    end

endmodule
